// File: rtl/t3_result_streamer.sv
// Transmit end of the ternary-MAC host link: snapshots a vector of signed results and
// streams them out LSB byte first over a valid/ack handshake, followed by an XOR checksum.
module t3_result_streamer #(
    parameter int N_OUT = 4,
    parameter int ACC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic [N_OUT*ACC_W-1:0]   results,
    output logic                     busy,
    output logic [7:0]               data_out,
    output logic                     data_valid,
    input  logic                     data_ack,
    output logic                     frame_last,
    output logic                     done
);

    localparam int BYTES = ACC_W / 8;
    localparam int TOTAL = N_OUT * BYTES;
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CSUM,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [N_OUT*ACC_W-1:0]   shadow_q;
    logic [IDX_W-1:0]         byte_idx_q;
    logic [7:0]               csum_q;
    logic [7:0]               cur_byte;
    logic                     accept;
    logic                     capture;

    // Byte byte_idx_q of the shadow vector; result 0 occupies the lowest bytes.
    always_comb begin
        cur_byte = '0;
        for (int unsigned b = 0; b < TOTAL; b++) begin
            if (byte_idx_q == IDX_W'(b)) begin
                cur_byte = shadow_q[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        data_valid = 1'b0;
        data_out   = '0;
        frame_last = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                capture = ena & start;
                if (capture) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                busy       = 1'b1;
                data_valid = 1'b1;
                data_out   = cur_byte;
                accept     = ena & data_ack;
                if (accept && byte_idx_q == LAST_IDX) begin
                    state_d = CSUM;
                end
            end
            CSUM: begin
                busy       = 1'b1;
                data_valid = 1'b1;
                data_out   = csum_q;
                frame_last = 1'b1;
                accept     = ena & data_ack;
                if (accept) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (ena) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                shadow_q   <= results;
                byte_idx_q <= '0;
                csum_q     <= '0;
            end else if (state_q == SEND && accept) begin
                csum_q     <= csum_q ^ cur_byte;
                byte_idx_q <= byte_idx_q + 1'b1;
            end
        end
    end

endmodule
